// File: rtl/dsp_stage_sequencer.sv
// Purpose: sequences one sample block through FIR -> FFT -> IFFT -> DMA-out under a per-block stage mask.
// Latency: a start pulse is issued the cycle after block_ready or the previous stage's done pulse.
// Backpressure: one-deep request queue; further block_ready pulses are dropped and flagged on overrun.
//
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   block_ready, stage_mask      block request pulse and its stage enables (bit0 FIR .. bit3 DMA)
//   abort, clear_error           drop current block / leave the error state
//   fir/fft/ifft/dma_done        engine completion pulses
//   start_fir/fft/ifft/dma_out   one-cycle engine start pulses
//   busy, stage, error           status (stage: 0 IDLE, 1 FIR, 2 FFT, 3 IFFT, 4 DMA, 7 ERR)
//   block_done, block_count      block completion pulse and wrapping completed-block counter
//   overrun                      sticky flag: a block request was dropped
module dsp_stage_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 block_ready,
    input  logic [3:0]           stage_mask,
    input  logic                 abort,
    input  logic                 clear_error,
    input  logic                 fir_done,
    input  logic                 fft_done,
    input  logic                 ifft_done,
    input  logic                 dma_done,
    output logic                 start_fir,
    output logic                 start_fft,
    output logic                 start_ifft,
    output logic                 start_dma_out,
    output logic                 busy,
    output logic [2:0]           stage,
    output logic                 block_done,
    output logic                 error,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] block_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FIR  = 3'd1,
        S_FFT  = 3'd2,
        S_IFFT = 3'd3,
        S_DMA  = 3'd4,
        S_ERR  = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [3:0]           mask_q, mask_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [3:0]           pend_mask_q, pend_mask_d;
    logic                 overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 block_done_q, block_done_d;
    logic [3:0]           start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;

    logic                 cur_done;
    logic [3:0]           rest_mask;
    logic                 take;
    logic [3:0]           take_mask;
    logic                 enter;
    logic                 finish;

    // First enabled stage in fixed pipeline order; IDLE when nothing is left.
    function automatic state_t lowest_stage(input logic [3:0] m);
        state_t r;
        if (m[0])      r = S_FIR;
        else if (m[1]) r = S_FFT;
        else if (m[2]) r = S_IFFT;
        else if (m[3]) r = S_DMA;
        else           r = S_IDLE;
        return r;
    endfunction

    // Only the engine owning the current stage can advance it; the remaining
    // mask drops the current and all earlier stages.
    always_comb begin
        cur_done  = 1'b0;
        rest_mask = 4'b0000;
        case (state_q)
            S_FIR:   begin cur_done = fir_done;  rest_mask = mask_q & 4'b1110; end
            S_FFT:   begin cur_done = fft_done;  rest_mask = mask_q & 4'b1100; end
            S_IFFT:  begin cur_done = ifft_done; rest_mask = mask_q & 4'b1000; end
            S_DMA:   begin cur_done = dma_done;  rest_mask = 4'b0000;          end
            default: begin cur_done = 1'b0;      rest_mask = 4'b0000;          end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        mask_d       = mask_q;
        pend_vld_d   = pend_vld_q;
        pend_mask_d  = pend_mask_q;
        overrun_d    = overrun_q;
        count_d      = count_q;
        block_done_d = 1'b0;
        start_d      = 4'b0000;
        take         = 1'b0;
        take_mask    = 4'b0000;
        enter        = 1'b0;
        finish       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clear_error) overrun_d = 1'b0;
                if (abort) begin
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q) begin
                    // Queued request goes first; a fresh request refills the queue.
                    take      = 1'b1;
                    take_mask = pend_mask_q;
                    if (block_ready) pend_mask_d = stage_mask;
                    else             pend_vld_d  = 1'b0;
                end else if (block_ready) begin
                    take      = 1'b1;
                    take_mask = stage_mask;
                end
            end

            S_FIR, S_FFT, S_IFFT, S_DMA: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    timer_d    = '0;
                    pend_vld_d = 1'b0;
                end else begin
                    if (clear_error) overrun_d = 1'b0;
                    // timer_q == 0 is the start cycle itself, where done is not honoured.
                    if (cur_done && (timer_q != '0)) begin
                        state_d = lowest_stage(rest_mask);
                        timer_d = '0;
                        if (rest_mask == 4'b0000) finish = 1'b1;
                        else                      enter  = 1'b1;
                    end else if (timer_q == TMAX) begin
                        state_d = S_ERR;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                    if (block_ready) begin
                        if (!pend_vld_q) begin
                            pend_vld_d  = 1'b1;
                            pend_mask_d = stage_mask;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end

            S_ERR: begin
                if (clear_error) begin
                    state_d    = S_IDLE;
                    overrun_d  = 1'b0;
                    pend_vld_d = 1'b0;
                end else if (block_ready) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        if (take) begin
            mask_d = take_mask;
            if (take_mask == 4'b0000) begin
                finish = 1'b1;
            end else begin
                state_d = lowest_stage(take_mask);
                timer_d = '0;
                enter   = 1'b1;
            end
        end

        if (finish) begin
            block_done_d = 1'b1;
            count_d      = count_q + CNT_WIDTH'(1);
        end

        if (enter) begin
            case (state_d)
                S_FIR:   start_d = 4'b0001;
                S_FFT:   start_d = 4'b0010;
                S_IFFT:  start_d = 4'b0100;
                S_DMA:   start_d = 4'b1000;
                default: start_d = 4'b0000;
            endcase
        end

        busy_d  = (state_d != S_IDLE);
        error_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            mask_q       <= 4'b0000;
            pend_vld_q   <= 1'b0;
            pend_mask_q  <= 4'b0000;
            overrun_q    <= 1'b0;
            count_q      <= '0;
            block_done_q <= 1'b0;
            start_q      <= 4'b0000;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            mask_q       <= mask_d;
            pend_vld_q   <= pend_vld_d;
            pend_mask_q  <= pend_mask_d;
            overrun_q    <= overrun_d;
            count_q      <= count_d;
            block_done_q <= block_done_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign start_fir     = start_q[0];
    assign start_fft     = start_q[1];
    assign start_ifft    = start_q[2];
    assign start_dma_out = start_q[3];
    assign busy          = busy_q;
    assign stage         = state_q;
    assign block_done    = block_done_q;
    assign error         = error_q;
    assign overrun       = overrun_q;
    assign block_count   = count_q;

endmodule
